// File: rtl/mapper_ram_bridge.sv
// Bridges mapper RAM accesses onto the shared SDRAM request/ready port,
// stalling the CPU per access, with a one-entry read cache and a ready timeout.
module mapper_ram_bridge #(
  parameter int unsigned ADDR_W  = 27,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] map_addr,
  input  logic              map_ram_cs,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_din,
  input  logic              rom_wp,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_dout,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic                cache_valid;
  logic [ADDR_W-1:0]   cache_addr;
  logic [7:0]          cache_data;
  logic [CNT_W-1:0]    cnt;
  logic                op_rd;

  logic acc_c, hit_c, wp_drop_c;
  logic issue, fast_hit, rd_done, wr_done, tmo;

  // Read wins when both strobes are high
  assign acc_c     = map_ram_cs & (cpu_rd | cpu_wr);
  assign hit_c     = cpu_rd & cache_valid & (map_addr == cache_addr);
  assign wp_drop_c = ~cpu_rd & cpu_wr & rom_wp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    fast_hit  = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc_c) begin
          if (hit_c) begin
            fast_hit  = 1'b1;
            state_nxt = S_DONE;
          end else if (wp_drop_c) begin
            state_nxt = S_DONE;
          end else begin
            issue     = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_ready) begin
          rd_done   = op_rd;
          wr_done   = ~op_rd;
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          tmo       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!map_ram_cs || !(cpu_rd || cpu_wr)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stall starts in the same cycle the missing access appears
  assign cpu_wait = issue | (state == S_REQ) | (state == S_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout    <= 8'hFF;
      mem_addr    <= '1;
      mem_din     <= 8'h00;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      timeout_err <= 1'b0;
      op_rd       <= 1'b0;
      cnt         <= '0;
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= 8'h00;
    end else begin
      mem_rd <= issue & cpu_rd;
      mem_wr <= issue & ~cpu_rd;
      if (issue) begin
        mem_addr <= map_addr;
        mem_din  <= cpu_din;
        op_rd    <= cpu_rd;
      end
      if (state == S_REQ)       cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
      if (fast_hit) cpu_dout <= cache_data;
      if (rd_done) begin
        cpu_dout    <= mem_dout;
        cache_addr  <= mem_addr;
        cache_data  <= mem_dout;
        cache_valid <= 1'b1;
      end
      // Write-through keeps a matching cache entry coherent
      if (wr_done && cache_valid && (cache_addr == mem_addr)) cache_data <= mem_din;
      if (tmo) begin
        cpu_dout    <= 8'hFF;
        timeout_err <= 1'b1;
        cache_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mapper_ram_bridge.sv
// Directed bench for mapper_ram_bridge: misses, cache hits, write-through,
// ROM write drop, timeout, held/dropped strobes and async reset.
module tb_mapper_ram_bridge;

  localparam int unsigned ADDR_W = 27;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] map_addr;
  logic              map_ram_cs, cpu_rd, cpu_wr, rom_wp;
  logic [7:0]        cpu_din, cpu_dout, mem_din, mem_dout;
  logic              cpu_wait, mem_rd, mem_wr, mem_ready, timeout_err;
  logic [ADDR_W-1:0] mem_addr;

  int vectors = 0;
  int miscompares = 0;
  int n_rd = 0;
  int n_wr = 0;

  mapper_ram_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .map_addr(map_addr), .map_ram_cs(map_ram_cs),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .rom_wp(rom_wp),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready), .mem_dout(mem_dout),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_rd === 1'b1) n_rd++;
    if (mem_wr === 1'b1) n_wr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Cycle 0 is the cycle the access appears; ready is driven in cycle k+1
  // (k=0: never). Returns cycles with cpu_wait high and cycle-1 request state.
  task automatic access(input logic [ADDR_W-1:0] a, input logic rd, input logic wr,
                        input logic [7:0] din, input logic wp, input int k, input int drop_at,
                        output int wcyc, output logic rd1, output logic wr1, output logic [7:0] din1);
    map_addr = a; map_ram_cs = 1'b1; cpu_rd = rd; cpu_wr = wr; cpu_din = din; rom_wp = wp;
    mem_ready = 1'b0;
    wcyc = 0; rd1 = 1'b0; wr1 = 1'b0; din1 = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) begin rd1 = mem_rd; wr1 = mem_wr; din1 = mem_din; end
      if (!cpu_wait) break;
      wcyc++;
      @(posedge clk); #1;
      mem_ready = (k > 0) && (c + 1 == k + 1);
      if (c + 1 == drop_at) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
    end
    mem_ready = 1'b0;
  endtask

  task automatic release_strobes(input int hold);
    repeat (hold) cyc();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    cyc();
  endtask

  int w, rd0, wr0;
  logic r1, w1;
  logic [7:0] d1;

  initial begin
    reset_n = 1'b0; map_addr = '0; map_ram_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_din = 8'h00; rom_wp = 1'b0; mem_ready = 1'b0; mem_dout = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
    check("rst_mem_addr", 32'(mem_addr), 32'h7FF_FFFF);
    check("rst_cpu_wait", 32'(cpu_wait), 32'h0);
    check("rst_mem_rdwr", 32'({mem_rd, mem_wr}), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc();

    // Read miss, ready after k=3
    mem_dout = 8'h5A; rd0 = n_rd;
    access(27'h02000, 1'b1, 1'b0, 8'h00, 1'b0, 3, -1, w, r1, w1, d1);
    check("miss_wait_cycles", 32'(w), 32'd5);
    check("miss_rd_at_n1", 32'(r1), 32'h1);
    check("miss_mem_addr", 32'(mem_addr), 32'h02000);
    release_strobes(1);
    check("miss_rd_count", 32'(n_rd - rd0), 32'd1);
    check("miss_cpu_dout", 32'(cpu_dout), 32'h5A);

    // Repeat read hits the cache
    mem_dout = 8'h00; rd0 = n_rd;
    access(27'h02000, 1'b1, 1'b0, 8'h00, 1'b0, 1, -1, w, r1, w1, d1);
    check("hit_wait_cycles", 32'(w), 32'd0);
    release_strobes(1);
    check("hit_rd_count", 32'(n_rd - rd0), 32'd0);
    check("hit_cpu_dout", 32'(cpu_dout), 32'h5A);

    // Different address misses (k=1)
    mem_dout = 8'hA5; rd0 = n_rd;
    access(27'h04000, 1'b1, 1'b0, 8'h00, 1'b0, 1, -1, w, r1, w1, d1);
    check("miss2_wait_cycles", 32'(w), 32'd3);
    release_strobes(1);
    check("miss2_rd_count", 32'(n_rd - rd0), 32'd1);
    check("miss2_cpu_dout", 32'(cpu_dout), 32'hA5);

    // Refill 0x02000 (k=2), then write-through 0x33
    mem_dout = 8'h5A;
    access(27'h02000, 1'b1, 1'b0, 8'h00, 1'b0, 2, -1, w, r1, w1, d1);
    check("refill_wait_cycles", 32'(w), 32'd4);
    release_strobes(1);
    mem_dout = 8'hEE; rd0 = n_rd; wr0 = n_wr;
    access(27'h02000, 1'b0, 1'b1, 8'h33, 1'b0, 2, -1, w, r1, w1, d1);
    check("wr_wait_cycles", 32'(w), 32'd4);
    check("wr_pulse_at_n1", 32'(w1), 32'h1);
    check("wr_mem_din", 32'(d1), 32'h33);
    release_strobes(1);
    check("wr_counts", 32'({16'(n_rd - rd0), 16'(n_wr - wr0)}), 32'h0000_0001);
    check("wr_cpu_dout_kept", 32'(cpu_dout), 32'h5A);
    rd0 = n_rd;
    access(27'h02000, 1'b1, 1'b0, 8'h00, 1'b0, 1, -1, w, r1, w1, d1);
    check("wr_hit_wait", 32'(w), 32'd0);
    release_strobes(1);
    check("wr_hit_rd_count", 32'(n_rd - rd0), 32'd0);
    check("wr_hit_cpu_dout", 32'(cpu_dout), 32'h33);

    // ROM-protected write is dropped
    wr0 = n_wr;
    access(27'h02000, 1'b0, 1'b1, 8'h77, 1'b1, 1, -1, w, r1, w1, d1);
    check("wp_wait_cycles", 32'(w), 32'd0);
    release_strobes(1);
    check("wp_wr_count", 32'(n_wr - wr0), 32'd0);
    access(27'h02000, 1'b1, 1'b0, 8'h00, 1'b0, 1, -1, w, r1, w1, d1);
    release_strobes(1);
    check("wp_cache_kept", 32'(cpu_dout), 32'h33);

    // Timeout: no ready ever
    access(27'h06000, 1'b1, 1'b0, 8'h00, 1'b0, 0, -1, w, r1, w1, d1);
    check("tmo_wait_cycles", 32'(w), 32'd10);
    release_strobes(1);
    check("tmo_cpu_dout", 32'(cpu_dout), 32'hFF);
    check("tmo_err", 32'(timeout_err), 32'h1);
    mem_dout = 8'h33; rd0 = n_rd;
    access(27'h02000, 1'b1, 1'b0, 8'h00, 1'b0, 1, -1, w, r1, w1, d1);
    check("tmo_cache_invalid_wait", 32'(w), 32'd3);
    release_strobes(1);
    check("tmo_cache_invalid_rd", 32'(n_rd - rd0), 32'd1);

    // Strobes held 10 cycles after completion
    mem_dout = 8'h11; rd0 = n_rd;
    access(27'h08000, 1'b1, 1'b0, 8'h00, 1'b0, 2, -1, w, r1, w1, d1);
    release_strobes(10);
    check("hold_rd_count", 32'(n_rd - rd0), 32'd1);
    check("hold_cpu_dout", 32'(cpu_dout), 32'h11);

    // Strobes dropped mid-WAIT; transaction still completes
    mem_dout = 8'hC3; rd0 = n_rd;
    access(27'h0A000, 1'b1, 1'b0, 8'h00, 1'b0, 4, 3, w, r1, w1, d1);
    check("drop_wait_cycles", 32'(w), 32'd6);
    cyc();
    check("drop_rd_count", 32'(n_rd - rd0), 32'd1);
    check("drop_cpu_dout", 32'(cpu_dout), 32'hC3);
    mem_dout = 8'h99;
    access(27'h0C000, 1'b1, 1'b0, 8'h00, 1'b0, 1, -1, w, r1, w1, d1);
    check("drop_back_to_idle", 32'(w), 32'd3);
    release_strobes(1);

    // Async reset during WAIT, then a stray ready
    map_addr = 27'h0E000; map_ram_cs = 1'b1; cpu_rd = 1'b1;
    repeat (3) cyc();
    reset_n = 1'b0; cpu_rd = 1'b0;
    #1;
    check("arst_cpu_dout", 32'(cpu_dout), 32'hFF);
    check("arst_mem_addr", 32'(mem_addr), 32'h7FF_FFFF);
    check("arst_wait_err", 32'({cpu_wait, timeout_err, mem_rd, mem_wr}), 32'h0);
    cyc();
    reset_n = 1'b1;
    rd0 = n_rd;
    mem_ready = 1'b1; mem_dout = 8'h42;
    cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    check("stray_ready_state", 32'({cpu_wait, cpu_dout}), 32'h0FF);
    check("stray_ready_addr", 32'(mem_addr), 32'h7FF_FFFF);
    check("stray_ready_rd", 32'(n_rd - rd0), 32'd0);
    @(posedge clk); #1;
    mem_dout = 8'h5A;
    access(27'h02000, 1'b1, 1'b0, 8'h00, 1'b0, 1, -1, w, r1, w1, d1);
    check("post_rst_cache_invalid", 32'(w), 32'd3);
    release_strobes(1);
    check("post_rst_cpu_dout", 32'(cpu_dout), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
